rv32_decode_stage: RTL and testbench

Instruction-decode (ID) stage of the 5-stage RV32I-subset pipeline, between the IF/ID register and the execute stage. Decodes the instruction into control signals, reads the 32×32 register file, sign-extends the immediate, and registers everything into the ID/EX pipeline register. It also hosts the register-file write port driven by writeback.

---
 rtl/rv32_decode_stage_if.sv | 44 ++++
 rtl/rv32_decode_stage.sv | 207 ++++++++++++++++++++
 tb/tb_rv32_decode_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rv32_decode_stage_if.sv
// IF/ID inputs, writeback port and ID/EX outputs of the RV32I decode stage.
// The master side drives the instruction and writeback; the slave side is the stage.
interface rv32_decode_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] i_instr_d;
    logic [DATA_WIDTH-1:0] i_pc_d;
    logic [DATA_WIDTH-1:0] i_pc4_d;
    logic                  i_reg_write_w;
    logic [ADDR_WIDTH-1:0] i_rd_addr_w;
    logic [DATA_WIDTH-1:0] i_result_w;
    logic                  i_zero_e;

    logic                  o_regwrite_e;
    logic                  o_memwrite_e;
    logic                  o_jump_e;
    logic                  o_branch_e;
    logic                  o_alusrc_e;
    logic [1:0]            o_resultsrc_e;
    logic [2:0]            o_aluctrl_e;
    logic [DATA_WIDTH-1:0] o_rs1_data_e;
    logic [DATA_WIDTH-1:0] o_rs2_data_e;
    logic [ADDR_WIDTH-1:0] o_rs1_addr_e;
    logic [ADDR_WIDTH-1:0] o_rs2_addr_e;
    logic [ADDR_WIDTH-1:0] o_rd_addr_e;
    logic [DATA_WIDTH-1:0] o_immext_e;
    logic [DATA_WIDTH-1:0] o_pc_e;
    logic [DATA_WIDTH-1:0] o_pc4_e;

    modport master (
        output i_instr_d, i_pc_d, i_pc4_d, i_reg_write_w, i_rd_addr_w, i_result_w, i_zero_e,
        input  o_regwrite_e, o_memwrite_e, o_jump_e, o_branch_e, o_alusrc_e, o_resultsrc_e,
               o_aluctrl_e, o_rs1_data_e, o_rs2_data_e, o_rs1_addr_e, o_rs2_addr_e,
               o_rd_addr_e, o_immext_e, o_pc_e, o_pc4_e
    );

    modport slave (
        input  i_instr_d, i_pc_d, i_pc4_d, i_reg_write_w, i_rd_addr_w, i_result_w, i_zero_e,
        output o_regwrite_e, o_memwrite_e, o_jump_e, o_branch_e, o_alusrc_e, o_resultsrc_e,
               o_aluctrl_e, o_rs1_data_e, o_rs2_data_e, o_rs1_addr_e, o_rs2_addr_e,
               o_rd_addr_e, o_immext_e, o_pc_e, o_pc4_e
    );
endinterface

// File: rtl/rv32_decode_stage.sv
// RV32I-subset decode stage: control decode, register file, immediate extension, ID/EX register.
// Define RF_BYPASS_EN to make a same-cycle writeback visible to the register reads.
module rv32_decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic              i_clk,
    input logic              i_rst,
    rv32_decode_stage_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

    logic [DATA_WIDTH-1:0] instr;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign instr    = bus.i_instr_d;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign rd_addr  = instr[11:7];

    // The ALU zero flag belongs to execute and does not influence decode.
    logic unused_zero;
    assign unused_zero = bus.i_zero_e;

    logic       regwrite;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic       alusrc;
    logic [1:0] resultsrc;
    logic [1:0] aluop;
    imm_src_t   immsrc;

    always_comb begin
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        jump      = 1'b0;
        branch    = 1'b0;
        alusrc    = 1'b0;
        resultsrc = 2'b00;
        aluop     = 2'b00;
        immsrc    = IMM_I;
        unique case (opcode)
            OP_LW: begin
                regwrite  = 1'b1;
                alusrc    = 1'b1;
                resultsrc = 2'b01;
            end
            OP_SW: begin
                immsrc   = IMM_S;
                alusrc   = 1'b1;
                memwrite = 1'b1;
            end
            OP_R: begin
                regwrite = 1'b1;
                aluop    = 2'b10;
            end
            OP_BEQ: begin
                immsrc = IMM_B;
                branch = 1'b1;
                aluop  = 2'b01;
            end
            OP_IALU: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                aluop    = 2'b10;
            end
            OP_JAL: begin
                regwrite  = 1'b1;
                immsrc    = IMM_J;
                resultsrc = 2'b10;
                jump      = 1'b1;
            end
            default: ;
        endcase
    end

    logic [2:0] aluctrl;

    always_comb begin
        aluctrl = ALU_ADD;
        case (aluop)
            2'b01: aluctrl = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  aluctrl = (opcode[5] & instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b001:  aluctrl = ALU_SLL;
                    3'b010,
                    3'b011:  aluctrl = ALU_SLT;
                    3'b100:  aluctrl = ALU_XOR;
                    3'b101:  aluctrl = ALU_SRL;
                    3'b110:  aluctrl = ALU_OR;
                    default: aluctrl = ALU_AND;
                endcase
            end
            default: aluctrl = ALU_ADD;
        endcase
    end

    logic [DATA_WIDTH-1:0] immext;

    always_comb begin
        unique case (immsrc)
            IMM_S:   immext = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   immext = {{(DATA_WIDTH-12){instr[31]}}, instr[7], instr[30:25],
                               instr[11:8], 1'b0};
            IMM_J:   immext = {{(DATA_WIDTH-20){instr[31]}}, instr[19:12], instr[20],
                               instr[30:21], 1'b0};
            default: immext = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
        endcase
    end

    logic [DATA_WIDTH-1:0] rf [NUM_REGS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (bus.i_reg_write_w && (bus.i_rd_addr_w != '0)) begin
            rf[bus.i_rd_addr_w] <= bus.i_result_w;
        end
    end

    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

`ifdef RF_BYPASS_EN
    logic wb_hit1;
    logic wb_hit2;

    assign wb_hit1 = bus.i_reg_write_w && (bus.i_rd_addr_w == rs1_addr);
    assign wb_hit2 = bus.i_reg_write_w && (bus.i_rd_addr_w == rs2_addr);

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) rs1_data = wb_hit1 ? bus.i_result_w : rf[rs1_addr];
        if (rs2_addr != '0) rs2_data = wb_hit2 ? bus.i_result_w : rf[rs2_addr];
    end
`else
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) rs1_data = rf[rs1_addr];
        if (rs2_addr != '0) rs2_data = rf[rs2_addr];
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_regwrite_e  <= 1'b0;
            bus.o_memwrite_e  <= 1'b0;
            bus.o_jump_e      <= 1'b0;
            bus.o_branch_e    <= 1'b0;
            bus.o_alusrc_e    <= 1'b0;
            bus.o_resultsrc_e <= 2'b00;
            bus.o_aluctrl_e   <= 3'b000;
            bus.o_rs1_data_e  <= '0;
            bus.o_rs2_data_e  <= '0;
            bus.o_rs1_addr_e  <= '0;
            bus.o_rs2_addr_e  <= '0;
            bus.o_rd_addr_e   <= '0;
            bus.o_immext_e    <= '0;
            bus.o_pc_e        <= '0;
            bus.o_pc4_e       <= '0;
        end else begin
            bus.o_regwrite_e  <= regwrite;
            bus.o_memwrite_e  <= memwrite;
            bus.o_jump_e      <= jump;
            bus.o_branch_e    <= branch;
            bus.o_alusrc_e    <= alusrc;
            bus.o_resultsrc_e <= resultsrc;
            bus.o_aluctrl_e   <= aluctrl;
            bus.o_rs1_data_e  <= rs1_data;
            bus.o_rs2_data_e  <= rs2_data;
            bus.o_rs1_addr_e  <= rs1_addr;
            bus.o_rs2_addr_e  <= rs2_addr;
            bus.o_rd_addr_e   <= rd_addr;
            bus.o_immext_e    <= immext;
            bus.o_pc_e        <= bus.i_pc_d;
            bus.o_pc4_e       <= bus.i_pc4_d;
        end
    end
endmodule

// File: tb/tb_rv32_decode_stage.sv
// Randomized bench for rv32_decode_stage against an instruction-level reference model.
// Honors RF_BYPASS_EN the same way as the design build.
module tb_rv32_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rv32_decode_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    rv32_decode_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mreg [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] read_model(input logic [4:0] a, input logic we,
                                               input logic [4:0] rdw, input logic [31:0] res);
        if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (we && rdw == a) return res;
`endif
        return mreg[a];
    endfunction

    // Apply one instruction and writeback before an edge, check the ID/EX outputs after it.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                        input logic [4:0] rdw, input logic [31:0] res, input logic rs);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        e_rw, e_mw, e_j, e_b, e_as;
        logic [1:0]  e_res;
        logic [2:0]  e_alu;
        int          imm;
        logic [31:0] e_d1, e_d2;
        @(negedge clk);
        rst               = rs;
        bus.i_instr_d     = ins;
        bus.i_pc_d        = pc;
        bus.i_pc4_d       = pc + 32'd4;
        bus.i_reg_write_w = we;
        bus.i_rd_addr_w   = rdw;
        bus.i_result_w    = res;
        bus.i_zero_e      = 1'($urandom_range(0, 1));

        op = ins[6:0];
        f3 = ins[14:12];
        {e_rw, e_mw, e_j, e_b, e_as} = 5'b0;
        e_res = 2'd0;
        e_alu = 3'd0;
        imm = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
        case (op)
            7'h03: begin e_rw = 1; e_as = 1; e_res = 2'd1; end
            7'h23: begin
                e_mw = 1; e_as = 1;
                imm = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
            end
            7'h33, 7'h13: begin
                e_rw = 1;
                e_as = (op == 7'h13);
                case (f3)
                    3'd0: e_alu = (op == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
                    3'd1: e_alu = 3'd6;
                    3'd2, 3'd3: e_alu = 3'd5;
                    3'd4: e_alu = 3'd4;
                    3'd5: e_alu = 3'd7;
                    3'd6: e_alu = 3'd3;
                    default: e_alu = 3'd2;
                endcase
            end
            7'h63: begin
                e_b = 1; e_alu = 3'd1;
                imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                      + int'(ins[11:8]) * 2;
            end
            7'h6f: begin
                e_rw = 1; e_j = 1; e_res = 2'd2;
                imm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096
                      + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            end
            default: ;
        endcase
        e_d1 = read_model(ins[19:15], we, rdw, res);
        e_d2 = read_model(ins[24:20], we, rdw, res);

        @(posedge clk);
        #1;
        if (rs) begin
            check("rst_ctrl", {27'd0, bus.o_regwrite_e, bus.o_memwrite_e, bus.o_jump_e,
                               bus.o_branch_e, bus.o_alusrc_e}, 32'd0);
            check("rst_res_alu", {27'd0, bus.o_resultsrc_e, bus.o_aluctrl_e}, 32'd0);
            check("rst_rs1_data", bus.o_rs1_data_e, 32'd0);
            check("rst_rs2_data", bus.o_rs2_data_e, 32'd0);
            check("rst_addrs", {17'd0, bus.o_rs1_addr_e, bus.o_rs2_addr_e, bus.o_rd_addr_e}, 32'd0);
            check("rst_imm", bus.o_immext_e, 32'd0);
            check("rst_pc", bus.o_pc_e, 32'd0);
            check("rst_pc4", bus.o_pc4_e, 32'd0);
            for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        end else begin
            check("regwrite", {31'd0, bus.o_regwrite_e}, {31'd0, e_rw});
            check("memwrite", {31'd0, bus.o_memwrite_e}, {31'd0, e_mw});
            check("jump", {31'd0, bus.o_jump_e}, {31'd0, e_j});
            check("branch", {31'd0, bus.o_branch_e}, {31'd0, e_b});
            check("alusrc", {31'd0, bus.o_alusrc_e}, {31'd0, e_as});
            check("resultsrc", {30'd0, bus.o_resultsrc_e}, {30'd0, e_res});
            check("aluctrl", {29'd0, bus.o_aluctrl_e}, {29'd0, e_alu});
            check("rs1_data", bus.o_rs1_data_e, e_d1);
            check("rs2_data", bus.o_rs2_data_e, e_d2);
            check("rs1_addr", {27'd0, bus.o_rs1_addr_e}, {27'd0, ins[19:15]});
            check("rs2_addr", {27'd0, bus.o_rs2_addr_e}, {27'd0, ins[24:20]});
            check("rd_addr", {27'd0, bus.o_rd_addr_e}, {27'd0, ins[11:7]});
            check("immext", bus.o_immext_e, 32'(imm));
            check("pc", bus.o_pc_e, pc);
            check("pc4", bus.o_pc4_e, pc + 32'd4);
            if (we && rdw != 5'd0) mreg[rdw] = res;
        end
    endtask

    initial begin
        logic [6:0]  ops [7];
        logic [31:0] r, ins;
        logic [4:0]  rdw;
        logic        we;
        ops = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6f, 7'h00};
        for (int i = 0; i < 32; i++) mreg[i] = 32'hDEAD_BEEF;
        bus.i_instr_d = '0; bus.i_pc_d = '0; bus.i_pc4_d = '0;
        bus.i_reg_write_w = 1'b0; bus.i_rd_addr_w = '0; bus.i_result_w = '0; bus.i_zero_e = 1'b0;

        step(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        step(32'h0, 32'h0, 1'b1, 5'd3, 32'h55, 1'b1);
        for (int i = 1; i < 32; i++)
            step(32'h33 | (32'(i) << 15) | (32'(i) << 20), 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        step(32'h0050_0113, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'hFF71_8393, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'h0023_E233, 32'h108, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'h0272_8863, 32'h10C, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'h0041_A233, 32'h110, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'h0000_0000, 32'h114, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'h0000_0000, 32'h118, 1'b1, 5'd2, 32'h37, 1'b0);
        step(32'h0001_0093, 32'h11C, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'h0000_0000, 32'h120, 1'b1, 5'd0, 32'h99, 1'b0);
        step(32'h0000_0093, 32'h124, 1'b0, 5'd0, 32'h0, 1'b0);
        step(32'h0000_0000, 32'h128, 1'b1, 5'd5, 32'h11, 1'b0);
        step(32'h0002_8333, 32'h12C, 1'b1, 5'd5, 32'hAB, 1'b0);
        step(32'h0002_8333, 32'h130, 1'b0, 5'd0, 32'h0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            r   = $urandom;
            ins = {r[31:7], ops[$urandom_range(0, 6)]};
            if ($urandom_range(0, 6) == 0) ins[6:0] = 7'($urandom);
            we  = 1'($urandom_range(0, 1));
            rdw = ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom);
            step(ins, $urandom & 32'hFFFF_FFFC, we, rdw, $urandom, ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
